// File: rtl/mont_enter_pkg.sv
// Shared types and helpers for the Montgomery-domain entry converter.
// Covers the FSM encoding, the latency formula and the construction of q.
package mont_enter_pkg;

  localparam int MONT_MAXW = 64;
  typedef logic [MONT_MAXW-1:0] mont_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mont_state_t;

  // Cycles from accepting A to the first cycle with out_valid high.
  function automatic int mont_enter_lat(input int rbits, input int steps);
    return rbits / steps + 1;
  endfunction

  // q = qH * 2^(logq-logqh) + 1
  function automatic mont_word_t mont_q(input int logq, input int logqh, input mont_word_t qh);
    return (qh << (logq - logqh)) | mont_word_t'(1);
  endfunction

endpackage

// File: rtl/mont_enter_seq_mod_dbl.sv
// Combinational y = 2*x mod q, valid for x < q.
// The compare and subtract run one bit wider than q so that 2*x never overflows.
module mod_dbl #(
  parameter int LOGQ = 60
) (
  input  logic [LOGQ-1:0] q,
  input  logic [LOGQ-1:0] x,
  output logic [LOGQ-1:0] y
);

  logic [LOGQ:0] d;
  logic [LOGQ:0] q_ext;
  logic [LOGQ:0] diff;

  always_comb begin
    d     = {x, 1'b0};
    q_ext = {1'b0, q};
    diff  = d - q_ext;
    y     = (d >= q_ext) ? diff[LOGQ-1:0] : d[LOGQ-1:0];
  end

endmodule

// File: rtl/mont_enter_seq.sv
// Sequential converter T = A * 2^RBITS mod q with q = qH * 2^(LOGQ-LOGQH) + 1.
// Performs STEPS modular doublings per RUN cycle, behind valid/ready handshakes.
module mont_enter_seq
  import mont_enter_pkg::*;
#(
  parameter int LOGQ  = 60,
  parameter int LOGQH = 17,
  parameter int RBITS = 60,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  T
);

  localparam int N     = mont_enter_lat(RBITS, STEPS) - 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  mont_state_t      state_q, state_d;
  logic [LOGQ-1:0]  acc_q, acc_d;
  logic [LOGQH-1:0] qh_q, qh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [LOGQ-1:0]  q_run;
  logic [LOGQ-1:0]  q_in;
  logic [LOGQ:0]    a_diff;
  logic [LOGQ-1:0]  a_red;
  logic [LOGQ-1:0]  chain [STEPS+1];

  assign q_run = LOGQ'(mont_q(LOGQ, LOGQH, mont_word_t'(qh_q)));
  // Initial reduction uses the qH arriving with A, since qh_q is only loaded on this edge.
  assign q_in   = LOGQ'(mont_q(LOGQ, LOGQH, mont_word_t'(qH)));
  assign a_diff = {1'b0, A} - {1'b0, q_in};
  assign a_red  = (A >= q_in) ? a_diff[LOGQ-1:0] : A;

  assign chain[0] = acc_q;
  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_dbl
      mod_dbl #(.LOGQ(LOGQ)) u_dbl (
        .q(q_run),
        .x(chain[gi]),
        .y(chain[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      qh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      qh_q    <= qh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    qh_d    = qh_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = a_red;
          qh_d    = qH;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = chain[STEPS];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    T         = acc_q;
  end

endmodule
